pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard and flush controller for the SimMIPS core: the clocked successor to the combinational CU. It sits beside the ID stage and drives per-boundary hold and flush vectors for an N-stage pipeline. It tracks in-flight loads in a scoreboard of configurable depth and counts down multi-cycle MDU (HI/LO) operations. Flushes are resolved from an exception stage index, and the block keeps a saturating stall-cycle counter.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hazard_scoreboard.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared SimMIPS pipeline constants: boundary-register indices, default
// pipeline geometry and the hazard controller's per-cycle action encoding.
package cpu_pkg;

  localparam int BND_IFID  = 0;
  localparam int BND_IDEX  = 1;
  localparam int BND_EXMEM = 2;
  localparam int BND_MEMWR = 3;

  localparam int DEF_STAGES     = 5;
  localparam int DEF_LOAD_DEPTH = 1;
  localparam int DEF_MDU_LAT    = 4;
  localparam int DEF_REG_AW     = 5;

  // Winning pipeline action for the current cycle, in priority order.
  typedef enum logic [2:0] {
    ACT_RUN,
    ACT_PAUSE,
    ACT_EXC,
    ACT_STALL,
    ACT_BRANCH
  } ctrl_act_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight load destinations; entry k mirrors boundary
// register k+1 and flags a read-after-load match for the instruction in ID.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEF_LOAD_DEPTH,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ld_v,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DEPTH-1:0]  clr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_en,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rt_en,
  output logic              hit
);

  logic [DEPTH-1:0]  lq_v;
  logic [REG_AW-1:0] lq_addr [DEPTH];

  // NOTE: sequential state uses non-blocking (<=) so every entry samples the
  // pre-edge value of its neighbour and the shift happens in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq_v <= '0;
    end else if (en) begin
      lq_v[0] <= ld_v && (ld_addr != '0) && !clr[0];
      for (int k = 1; k < DEPTH; k++) begin
        lq_v[k] <= lq_v[k-1] && !clr[k];
      end
    end
  end

  // NOTE: the address payload has no reset; it is only ever observed through
  // its valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      lq_addr[0] <= ld_addr;
      for (int k = 1; k < DEPTH; k++) begin
        lq_addr[k] <= lq_addr[k-1];
      end
    end
  end

  // NOTE: hit is given a default before the loop so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (lq_v[k] &&
          ((rs_en && (rs_addr != '0) && (rs_addr == lq_addr[k])) ||
           (rt_en && (rt_addr != '0) && (rt_addr == lq_addr[k])))) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Clocked pipeline hazard/flush controller: resolves pause, exception,
// load-use/MDU stalls and branch flushes into per-boundary hold and flush.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int LOAD_DEPTH = DEF_LOAD_DEPTH,
  parameter int MDU_LAT    = DEF_MDU_LAT,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int SW         = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic              id_rs_en_i,
  input  logic              id_rt_en_i,
  input  logic              id_load_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_mdu_start_i,
  input  logic              id_hilo_rd_i,
  input  logic              branch_flush_i,
  input  logic              exc_i,
  input  logic [SW-1:0]     exc_stage_i,
  output logic [STAGES-2:0] hold_o,
  output logic [STAGES-2:0] flush_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int NB  = STAGES - 1;
  localparam int MCW = $clog2(MDU_LAT + 1);

  logic                  lu_hit;
  logic                  mdu_hit;
  logic [MCW-1:0]        mdu_cnt;
  logic [31:0]           stall_cnt;
  logic [LOAD_DEPTH-1:0] sb_clr;
  ctrl_act_e             act;

  hazard_scoreboard #(
    .DEPTH  (LOAD_DEPTH),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (!pause_i),
    .ld_v    (id_load_i),
    .ld_addr (id_dest_i),
    .clr     (sb_clr),
    .rs_addr (id_rs_addr_i),
    .rs_en   (id_rs_en_i),
    .rt_addr (id_rt_addr_i),
    .rt_en   (id_rt_en_i),
    .hit     (lu_hit)
  );

  // Entry k tracks boundary k+1, so it drops out when that boundary is flushed.
  always_comb begin
    sb_clr = '0;
    for (int k = 0; k < LOAD_DEPTH; k++) begin
      sb_clr[k] = flush_o[k+1];
    end
  end

  assign mdu_hit = id_hilo_rd_i && (mdu_cnt != '0);

  always_comb begin
    act = ACT_RUN;
    if (pause_i)                 act = ACT_PAUSE;
    else if (exc_i)              act = ACT_EXC;
    else if (lu_hit || mdu_hit)  act = ACT_STALL;
    else if (branch_flush_i)     act = ACT_BRANCH;
  end

  // Reset drives a full-pipeline bubble straight from rst_n.
  always_comb begin
    hold_o  = '0;
    flush_o = '0;
    if (!rst_n) begin
      flush_o = '1;
    end else begin
      unique case (act)
        ACT_PAUSE:  hold_o = '1;
        ACT_EXC: begin
          for (int b = 0; b < NB; b++) begin
            flush_o[b] = (SW'(b) <= exc_stage_i);
          end
        end
        ACT_STALL: begin
          hold_o[BND_IFID]  = 1'b1;
          flush_o[BND_IDEX] = 1'b1;
        end
        ACT_BRANCH: flush_o[BND_IFID] = 1'b1;
        default: ;
      endcase
    end
  end

  // A start only counts once the issuing instruction actually leaves ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (!pause_i) begin
      if (id_mdu_start_i && !hold_o[BND_IFID] && !flush_o[BND_IDEX]) begin
        mdu_cnt <= MCW'(MDU_LAT);
      end else if (mdu_cnt != '0) begin
        mdu_cnt <= mdu_cnt - MCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((act == ACT_STALL) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table on the default
// configuration plus hand sequences for deep-scoreboard, MDU and reset cases.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause_i, exc_i, branch_flush_i;
  logic [2:0] exc_stage_i;
  logic [4:0] id_rs_addr_i, id_rt_addr_i, id_dest_i;
  logic       id_rs_en_i, id_rt_en_i, id_load_i, id_mdu_start_i, id_hilo_rd_i;
  logic [3:0] hold, flush, hold2, flush2;
  logic [31:0] stall_cnt, stall_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pause_i(pause_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_rs_en_i(id_rs_en_i), .id_rt_en_i(id_rt_en_i),
    .id_load_i(id_load_i), .id_dest_i(id_dest_i),
    .id_mdu_start_i(id_mdu_start_i), .id_hilo_rd_i(id_hilo_rd_i),
    .branch_flush_i(branch_flush_i), .exc_i(exc_i), .exc_stage_i(exc_stage_i),
    .hold_o(hold), .flush_o(flush), .stall_cnt_o(stall_cnt)
  );

  pipe_hazard_ctrl #(.LOAD_DEPTH(2)) dut_d2 (
    .clk(clk), .rst_n(rst_n), .pause_i(pause_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_rs_en_i(id_rs_en_i), .id_rt_en_i(id_rt_en_i),
    .id_load_i(id_load_i), .id_dest_i(id_dest_i),
    .id_mdu_start_i(id_mdu_start_i), .id_hilo_rd_i(id_hilo_rd_i),
    .branch_flush_i(branch_flush_i), .exc_i(exc_i), .exc_stage_i(exc_stage_i),
    .hold_o(hold2), .flush_o(flush2), .stall_cnt_o(stall_cnt2)
  );

  typedef struct {
    string      name;
    logic       pause, exc;
    logic [2:0] stage;
    logic       branch, load;
    logic [4:0] dest, rs;
    logic       rs_en;
    logic [4:0] rt;
    logic       rt_en, mdu, hilo;
    logic [3:0] e_hold, e_flush;
    int         e_stall;
  } vec_t;

  vec_t vec [25];

  function automatic vec_t mk(string name, logic pause, logic exc, logic [2:0] stage,
                              logic branch, logic load, logic [4:0] dest,
                              logic [4:0] rs, logic rs_en, logic [4:0] rt, logic rt_en,
                              logic mdu, logic hilo,
                              logic [3:0] e_hold, logic [3:0] e_flush, int e_stall);
    vec_t v;
    v.name = name; v.pause = pause; v.exc = exc; v.stage = stage;
    v.branch = branch; v.load = load; v.dest = dest; v.rs = rs; v.rs_en = rs_en;
    v.rt = rt; v.rt_en = rt_en; v.mdu = mdu; v.hilo = hilo;
    v.e_hold = e_hold; v.e_flush = e_flush; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    pause_i = 0; exc_i = 0; exc_stage_i = 0; branch_flush_i = 0;
    id_load_i = 0; id_dest_i = 0; id_rs_addr_i = 0; id_rs_en_i = 0;
    id_rt_addr_i = 0; id_rt_en_i = 0; id_mdu_start_i = 0; id_hilo_rd_i = 0;
  endtask

  task automatic apply(input vec_t v);
    pause_i = v.pause; exc_i = v.exc; exc_stage_i = v.stage; branch_flush_i = v.branch;
    id_load_i = v.load; id_dest_i = v.dest; id_rs_addr_i = v.rs; id_rs_en_i = v.rs_en;
    id_rt_addr_i = v.rt; id_rt_en_i = v.rt_en; id_mdu_start_i = v.mdu; id_hilo_rd_i = v.hilo;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Holds a HI/LO read in ID until it is released; pauses cycles [p_from, p_to).
  task automatic mdu_read(input int p_from, input int p_to, output int held);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle();
      id_hilo_rd_i = 1;
      pause_i = (i >= p_from) && (i < p_to);
      #1;
      if (i == 0) check("mdu_first_flush", 32'(flush), 32'h2);
      if (!hold[0]) break;
      held++;
    end
  endtask

  initial begin
    int held;

    vec[0]  = mk("idle",          0,0,0,0, 0,0,  0,0, 0,0, 0,0, 4'h0,4'h0,0);
    vec[1]  = mk("lw_r8",         0,0,0,0, 1,8,  0,0, 0,0, 0,0, 4'h0,4'h0,0);
    vec[2]  = mk("lu_rs8",        0,0,0,0, 0,0,  8,1, 0,0, 0,0, 4'h1,4'h2,0);
    vec[3]  = mk("lu_rs8_go",     0,0,0,0, 0,0,  8,1, 0,0, 0,0, 4'h0,4'h0,1);
    vec[4]  = mk("lw_r0",         0,0,0,0, 1,0,  0,0, 0,0, 0,0, 4'h0,4'h0,1);
    vec[5]  = mk("rd_r0",         0,0,0,0, 0,0,  0,1, 0,1, 0,0, 4'h0,4'h0,1);
    vec[6]  = mk("lw_r9",         0,0,0,0, 1,9,  0,0, 0,0, 0,0, 4'h0,4'h0,1);
    vec[7]  = mk("lu_rt9",        0,0,0,0, 0,0,  0,0, 9,1, 0,0, 4'h1,4'h2,1);
    vec[8]  = mk("lw_r10",        0,0,0,0, 1,10, 0,0, 0,0, 0,0, 4'h0,4'h0,2);
    vec[9]  = mk("rd10_no_en",    0,0,0,0, 0,0, 10,0,10,0, 0,0, 4'h0,4'h0,2);
    vec[10] = mk("branch_paused", 1,0,0,1, 0,0,  0,0, 0,0, 0,0, 4'hF,4'h0,2);
    vec[11] = mk("branch",        0,0,0,1, 0,0,  0,0, 0,0, 0,0, 4'h0,4'h1,2);
    vec[12] = mk("lw_r8_b",       0,0,0,0, 1,8,  0,0, 0,0, 0,0, 4'h0,4'h0,2);
    vec[13] = mk("exc3_vs_lu",    0,1,3,0, 0,0,  8,1, 0,0, 0,0, 4'h0,4'hF,2);
    vec[14] = mk("rd8_after_exc", 0,0,0,0, 0,0,  8,1, 0,0, 0,0, 4'h0,4'h0,2);
    vec[15] = mk("exc_stage0",    0,1,0,0, 0,0,  0,0, 0,0, 0,0, 4'h0,4'h1,2);
    vec[16] = mk("exc_stage1",    0,1,1,0, 0,0,  0,0, 0,0, 0,0, 4'h0,4'h3,2);
    vec[17] = mk("lw_r5",         0,0,0,0, 1,5,  0,0, 0,0, 0,0, 4'h0,4'h0,2);
    vec[18] = mk("lu_rs5_paused", 1,0,0,0, 0,0,  5,1, 0,0, 0,0, 4'hF,4'h0,2);
    vec[19] = mk("lu_rs5",        0,0,0,0, 0,0,  5,1, 0,0, 0,0, 4'h1,4'h2,2);
    vec[20] = mk("lu_rs5_go",     0,0,0,0, 0,0,  5,1, 0,0, 0,0, 4'h0,4'h0,3);
    vec[21] = mk("exc_paused",    1,1,3,0, 0,0,  0,0, 0,0, 0,0, 4'hF,4'h0,3);
    vec[22] = mk("lw_r7",         0,0,0,0, 1,7,  0,0, 0,0, 0,0, 4'h0,4'h0,3);
    vec[23] = mk("lu_vs_branch",  0,0,0,1, 0,0,  7,1, 0,0, 0,0, 4'h1,4'h2,3);
    vec[24] = mk("idle_end",      0,0,0,0, 0,0,  0,0, 0,0, 0,0, 4'h0,4'h0,4);

    // Reset state, observed while rst_n is still low.
    idle();
    #1;
    check("rst_hold",   32'(hold),  32'h0);
    check("rst_flush",  32'(flush), 32'hF);
    check("rst_stall",  stall_cnt,  32'h0);
    check("rst_flush2", 32'(flush2), 32'hF);
    @(negedge clk);
    rst_n = 1;

    // Vector table on the default (LOAD_DEPTH=1) instance.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      apply(vec[i]);
      #1;
      check({vec[i].name, "_hold"},  32'(hold),  32'(vec[i].e_hold));
      check({vec[i].name, "_flush"}, 32'(flush), 32'(vec[i].e_flush));
      check({vec[i].name, "_stall"}, stall_cnt,  32'(vec[i].e_stall));
    end

    // Deep scoreboard (LOAD_DEPTH=2).
    do_reset();
    @(negedge clk); idle(); id_load_i = 1; id_dest_i = 8; #1;
    check("d2_lw_hold", 32'(hold2), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); id_rs_addr_i = 8; id_rs_en_i = 1; #1;
      check("d2_lu_hold",  32'(hold2),  32'h1);
      check("d2_lu_flush", 32'(flush2), 32'h2);
    end
    @(negedge clk); idle(); id_rs_addr_i = 8; id_rs_en_i = 1; #1;
    check("d2_lu_go_hold", 32'(hold2), 32'h0);
    check("d2_lu_stall",   stall_cnt2, 32'd2);
    @(negedge clk); idle(); id_load_i = 1; id_dest_i = 9; #1;
    @(negedge clk); idle(); id_rs_addr_i = 1; id_rs_en_i = 1; #1;
    check("d2_gap_indep_hold", 32'(hold2), 32'h0);
    @(negedge clk); idle(); id_rs_addr_i = 9; id_rs_en_i = 1; #1;
    check("d2_gap_hold", 32'(hold2), 32'h1);
    @(negedge clk); idle(); id_rs_addr_i = 9; id_rs_en_i = 1; #1;
    check("d2_gap_go_hold", 32'(hold2), 32'h0);
    check("d2_gap_stall",   stall_cnt2, 32'd3);
    @(negedge clk); idle(); id_load_i = 1; id_dest_i = 0; #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); id_rs_addr_i = 0; id_rs_en_i = 1; #1;
      check("d2_r0_hold", 32'(hold2), 32'h0);
    end
    check("d2_r0_stall", stall_cnt2, 32'd3);

    // MDU: plain countdown, paused countdown, reload while busy.
    do_reset();
    @(negedge clk); idle(); id_mdu_start_i = 1; #1;
    check("mdu_start_hold", 32'(hold), 32'h0);
    mdu_read(99, 99, held);
    check("mdu_stall_cycles", 32'(held), 32'd4);
    check("mdu_stall_cnt",    stall_cnt, 32'd4);

    do_reset();
    @(negedge clk); idle(); id_mdu_start_i = 1;
    mdu_read(2, 5, held);
    check("mdu_pause_cycles", 32'(held), 32'd7);
    check("mdu_pause_cnt",    stall_cnt, 32'd4);

    do_reset();
    @(negedge clk); idle(); id_mdu_start_i = 1;
    @(negedge clk); idle(); id_mdu_start_i = 1;
    mdu_read(99, 99, held);
    check("mdu_reload_cycles", 32'(held), 32'd4);

    // Reset in the middle of an MDU stall.
    do_reset();
    @(negedge clk); idle(); id_mdu_start_i = 1;
    @(negedge clk); idle(); id_hilo_rd_i = 1; #1;
    check("rst_mid_pre_hold", 32'(hold), 32'h1);
    @(negedge clk); rst_n = 0; #1;
    check("rst_mid_hold",  32'(hold),  32'h0);
    check("rst_mid_flush", 32'(flush), 32'hF);
    check("rst_mid_stall", stall_cnt,  32'h0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); idle(); id_hilo_rd_i = 1; #1;
    check("rst_after_hold",  32'(hold),  32'h0);
    check("rst_after_flush", 32'(flush), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
